// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the master that did not own the port last wins.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic owner_i,
   output logic winner_o,
   output logic valid_o
);

   always_comb begin
      valid_o  = req0_i | req1_i;
      winner_o = M0;
      if (req0_i && req1_i) begin
         winner_o = ~owner_i;
      end else if (req1_i) begin
         winner_o = M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the processor (m0) and the loader/DMA (m1),
// one latched transaction at a time, with a watchdog abort.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [1:0]        m0_size_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_done_o,
   output logic              m0_err_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [1:0]        m1_size_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_done_o,
   output logic              m1_err_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [1:0]        mem_size_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              cpu_stall_o,
   output logic              owner_o
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              err_q, err_d;

   logic              pick_win;
   logic              pick_valid;
   logic              timeout_hit;
   logic              finish;
   logic [DATA_W-1:0] rd_val;
   logic              busy;
   logic              done;

   rr_pick2 u_pick (
      .req0_i   (m0_req_i),
      .req1_i   (m1_req_i),
      .owner_i  (owner_q),
      .winner_o (pick_win),
      .valid_o  (pick_valid)
   );

   // cnt_q counts completed BUSY cycles, so this is the TIMEOUT-th BUSY cycle.
   assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      err_d    = err_q;
      finish   = 1'b0;
      rd_val   = '0;

      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               owner_d = pick_win;
               we_d    = pick_win ? m1_we_i    : m0_we_i;
               size_d  = pick_win ? m1_size_i  : m0_size_i;
               addr_d  = pick_win ? m1_addr_i  : m0_addr_i;
               wdata_d = pick_win ? m1_wdata_i : m0_wdata_i;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            cnt_d = cnt_q + CntW'(1);
            // Ack takes priority over a simultaneous watchdog expiry.
            if (mem_ack_i) begin
               finish = 1'b1;
               rd_val = we_q ? '0 : mem_rdata_i;
               err_d  = 1'b0;
            end else if (timeout_hit) begin
               finish = 1'b1;
               rd_val = '0;
               err_d  = 1'b1;
            end
            if (finish) begin
               state_d = StDone;
               if (owner_q == M1) begin
                  rdata1_d = rd_val;
               end else begin
                  rdata0_d = rd_val;
               end
            end
         end
         StDone: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         owner_q  <= M1;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         size_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         err_q    <= err_d;
      end
   end

   assign busy = (state_q == StBusy);
   assign done = (state_q == StDone);

   assign mem_req_o   = busy;
   assign mem_we_o    = we_q;
   assign mem_size_o  = size_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   assign m0_gnt_o   = busy & (owner_q == M0);
   assign m1_gnt_o   = busy & (owner_q == M1);
   assign m0_done_o  = done & (owner_q == M0);
   assign m1_done_o  = done & (owner_q == M1);
   assign m0_err_o   = m0_done_o & err_q;
   assign m1_err_o   = m1_done_o & err_q;
   assign m0_rdata_o = rdata0_q;
   assign m1_rdata_o = rdata1_q;

   assign cpu_stall_o = m0_req_i & ~m0_done_o;
   assign owner_o     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences, random traffic.
module tb_dmem_arbiter;

   localparam int unsigned TO = 4;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct {
      logic        r0;
      logic        r1;
      cmd_t        c0;
      cmd_t        c1;
      int          d;
      logic [31:0] rd;
      logic        ew;
      logic        ee;
      logic [31:0] erd;
      logic        mid;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [1:0]  m0_size = '0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m0_gnt, m0_done, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [1:0]  m1_size = '0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        m1_gnt, m1_done, m1_err;
   logic [31:0] m1_rdata;
   logic        mem_req, mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        cpu_stall, owner;

   int          n_checks = 0;
   int          n_err = 0;
   logic [31:0] exp_rd [2];

   dmem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .m0_req_i    (m0_req),
      .m0_we_i     (m0_we),
      .m0_size_i   (m0_size),
      .m0_addr_i   (m0_addr),
      .m0_wdata_i  (m0_wdata),
      .m0_gnt_o    (m0_gnt),
      .m0_done_o   (m0_done),
      .m0_err_o    (m0_err),
      .m0_rdata_o  (m0_rdata),
      .m1_req_i    (m1_req),
      .m1_we_i     (m1_we),
      .m1_size_i   (m1_size),
      .m1_addr_i   (m1_addr),
      .m1_wdata_i  (m1_wdata),
      .m1_gnt_o    (m1_gnt),
      .m1_done_o   (m1_done),
      .m1_err_o    (m1_err),
      .m1_rdata_o  (m1_rdata),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_size_o  (mem_size),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_ack_i   (mem_ack),
      .cpu_stall_o (cpu_stall),
      .owner_o     (owner)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic cmd_t mk(input logic we, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] w);
      mk = '{we: we, size: sz, addr: a, wdata: w};
   endfunction

   function automatic cmd_t rnd_cmd();
      logic [1:0] sz;
      case ($urandom_range(0, 2))
         0:       sz = 2'b00;
         1:       sz = 2'b01;
         default: sz = 2'b11;
      endcase
      rnd_cmd = mk(1'($urandom_range(0, 1)), sz, $urandom, $urandom);
   endfunction

   task automatic drive(input logic r0, input logic r1, input cmd_t c0, input cmd_t c1);
      m0_req = r0; m0_we = c0.we; m0_size = c0.size; m0_addr = c0.addr; m0_wdata = c0.wdata;
      m1_req = r1; m1_we = c1.we; m1_size = c1.size; m1_addr = c1.addr; m1_wdata = c1.wdata;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_mem_req"}, 32'(mem_req), 0);
      chk({tag, "_gnt"}, {30'd0, m1_gnt, m0_gnt}, 0);
      chk({tag, "_done"}, {30'd0, m1_done, m0_done}, 0);
      chk({tag, "_err"}, {30'd0, m1_err, m0_err}, 0);
      chk({tag, "_rdata0"}, m0_rdata, exp_rd[0]);
      chk({tag, "_rdata1"}, m1_rdata, exp_rd[1]);
      chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'(m0_req));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_mem_req"}, 32'(mem_req), 0);
      chk({tag, "_mem_cmd"}, {29'd0, mem_we, mem_size}, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_gnt_done_err"}, {26'd0, m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err}, 0);
      chk({tag, "_rdata0"}, m0_rdata, 0);
      chk({tag, "_rdata1"}, m1_rdata, 0);
      chk({tag, "_owner"}, 32'(owner), 1);
   endtask

   // Starts in an IDLE cycle and returns in the IDLE cycle following the done pulse.
   task automatic run_txn(input string tag, input vec_t v);
      cmd_t ce;
      int   b;
      ce = v.ew ? v.c1 : v.c0;
      mem_ack = 1'b0;
      drive(v.r0, v.r1, v.c0, v.c1);
      chk({tag, "_idle_mem_req"}, 32'(mem_req), 0);
      step();
      for (b = 1; b <= int'(TO); b++) begin
         chk({tag, "_busy_mem_req"}, 32'(mem_req), 1);
         chk({tag, "_busy_gnt"}, {30'd0, m1_gnt, m0_gnt}, v.ew ? 32'd2 : 32'd1);
         chk({tag, "_busy_done"}, {30'd0, m1_done, m0_done}, 0);
         chk({tag, "_busy_owner"}, 32'(owner), 32'(v.ew));
         chk({tag, "_busy_cmd"}, {29'd0, mem_we, mem_size}, {29'd0, ce.we, ce.size});
         chk({tag, "_busy_addr"}, mem_addr, ce.addr);
         chk({tag, "_busy_wdata"}, mem_wdata, ce.wdata);
         chk({tag, "_busy_stall"}, 32'(cpu_stall), 32'(m0_req));
         if (v.mid && b == 1) begin
            if (v.ew) begin
               m1_req = 1'b0; m1_we = ~m1_we; m1_size = ~m1_size;
               m1_addr = ~m1_addr; m1_wdata = ~m1_wdata;
            end else begin
               m0_req = 1'b0; m0_we = ~m0_we; m0_size = ~m0_size;
               m0_addr = ~m0_addr; m0_wdata = ~m0_wdata;
            end
         end
         mem_ack   = (b == v.d + 1);
         mem_rdata = mem_ack ? v.rd : $urandom;
         step();
         mem_ack = 1'b0;
         if (b == v.d + 1) break;
      end
      chk({tag, "_done"}, {30'd0, m1_done, m0_done}, v.ew ? 32'd2 : 32'd1);
      chk({tag, "_err"}, {30'd0, m1_err, m0_err}, v.ee ? (v.ew ? 32'd2 : 32'd1) : 32'd0);
      exp_rd[v.ew] = v.erd;
      chk({tag, "_done_rdata0"}, m0_rdata, exp_rd[0]);
      chk({tag, "_done_rdata1"}, m1_rdata, exp_rd[1]);
      chk({tag, "_done_mem_req"}, 32'(mem_req), 0);
      chk({tag, "_done_gnt"}, {30'd0, m1_gnt, m0_gnt}, 0);
      chk({tag, "_done_stall"}, 32'(cpu_stall), 32'(m0_req & v.ew));
      if (v.ew) m1_req = 1'b0;
      else      m0_req = 1'b0;
      mem_ack = 1'($urandom_range(0, 1));
      step();
      mem_ack = 1'b0;
      chk_quiet({tag, "_after"});
   endtask

   vec_t tbl [10];

   initial begin
      vec_t  v;
      logic  pend [2];
      cmd_t  pc [2];
      logic  own_m;
      int    nt;

      exp_rd[0] = '0;
      exp_rd[1] = '0;

      tbl[0] = '{1, 1, mk(0, 2'b11, 32'h100, 0), mk(0, 2'b11, 32'h200, 0), 0, 32'h1111_1111,
                 0, 0, 32'h1111_1111, 0};
      tbl[1] = '{1, 1, mk(0, 2'b11, 32'h104, 0), mk(0, 2'b11, 32'h200, 0), 1, 32'h2222_2222,
                 1, 0, 32'h2222_2222, 0};
      tbl[2] = '{1, 1, mk(0, 2'b11, 32'h104, 0), mk(0, 2'b01, 32'h204, 0), 0, 32'h3333_3333,
                 0, 0, 32'h3333_3333, 0};
      tbl[3] = '{1, 1, mk(1, 2'b00, 32'h108, 7), mk(0, 2'b01, 32'h204, 0), 2, 32'h4444_4444,
                 1, 0, 32'h4444_4444, 0};
      tbl[4] = '{0, 1, mk(0, 2'b11, 32'h0, 0), mk(1, 2'b00, 32'h2000, 32'hAA), 1, 32'h5555_5555,
                 1, 0, 32'h0, 1};
      tbl[5] = '{1, 0, mk(0, 2'b11, 32'h1000_0004, 0), mk(0, 2'b11, 32'h0, 0), 2, 32'hDEAD_BEEF,
                 0, 0, 32'hDEAD_BEEF, 0};
      tbl[6] = '{1, 0, mk(0, 2'b01, 32'h1000_0008, 0), mk(0, 2'b11, 32'h0, 0), 3, 32'hCAFE_F00D,
                 0, 0, 32'hCAFE_F00D, 0};
      tbl[7] = '{1, 0, mk(0, 2'b11, 32'h1000_000C, 0), mk(0, 2'b11, 32'h0, 0), 20, 32'h1234_5678,
                 0, 1, 32'h0, 0};
      tbl[8] = '{0, 1, mk(0, 2'b11, 32'h0, 0), mk(0, 2'b11, 32'h3000, 0), 0, 32'h0BAD_CAFE,
                 1, 0, 32'h0BAD_CAFE, 0};
      tbl[9] = '{1, 0, mk(0, 2'b11, 32'h1000_0010, 0), mk(0, 2'b11, 32'h0, 0), 1, 32'h600D_600D,
                 0, 0, 32'h600D_600D, 0};

      // Reset state
      repeat (2) step();
      chk_reset_state("reset");
      rst_n = 1'b1;
      step();
      chk_quiet("post_reset");

      for (int i = 0; i < 10; i++) begin
         run_txn($sformatf("tbl%0d", i), tbl[i]);
      end

      // Spurious mem_ack while idle
      drive(0, 0, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hFFFF_FFFF;
         step();
         chk_quiet("spurious_ack");
      end
      mem_ack = 1'b0;

      // Reset in the middle of a transaction: no done, outputs clear at once
      drive(1, 1, mk(0, 2'b11, 32'h44, 0), mk(1, 2'b11, 32'h88, 32'h99));
      step();
      chk("rst_mid_busy_mem_req", 32'(mem_req), 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("rst_mid");
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      step();
      chk_reset_state("rst_held");
      rst_n = 1'b1;
      run_txn("post_rst_tie", '{1, 1, mk(0, 2'b11, 32'h44, 0), mk(1, 2'b11, 32'h88, 32'h99), 0,
                                32'h7777_0000, 0, 0, 32'h7777_0000, 0});

      // Random traffic against a transaction-level model
      own_m   = 1'b0;
      pend[0] = 1'b0;
      pend[1] = 1'b1;
      pc[0]   = rnd_cmd();
      pc[1]   = mk(1, 2'b11, 32'h88, 32'h99);
      nt      = 0;
      for (int it = 0; it < 200; it++) begin
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && $urandom_range(0, 2) != 0) begin
               pend[m] = 1'b1;
               pc[m]   = rnd_cmd();
            end
         end
         if (!pend[0] && !pend[1]) begin
            drive(0, 0, pc[0], pc[1]);
            mem_ack = 1'($urandom_range(0, 1));
            step();
            mem_ack = 1'b0;
            chk_quiet("rnd_idle");
            continue;
         end
         v.r0  = pend[0];
         v.r1  = pend[1];
         v.c0  = pc[0];
         v.c1  = pc[1];
         v.d   = $urandom_range(0, 5);
         v.rd  = $urandom;
         v.mid = 1'($urandom_range(0, 1));
         v.ew  = (pend[0] && pend[1]) ? ~own_m : (pend[0] ? 1'b0 : 1'b1);
         v.ee  = (v.d + 1 > int'(TO));
         v.erd = (v.ee || (v.ew ? pc[1].we : pc[0].we)) ? 32'h0 : v.rd;
         run_txn($sformatf("rnd%0d", nt), v);
         pend[v.ew] = 1'b0;
         own_m      = v.ew;
         nt++;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory access port between two requesters.
  - Master 0: processor load/store path.
  - Master 1: serial boot loader / DMA engine.
- Round-robin grant, one outstanding transaction at a time.
- Latches each command, holds it to the memory until acknowledged, and returns registered read data with a one-cycle done pulse.
- Watchdog counter aborts transactions the memory never acknowledges. Sits between the processor datapath, the loader and data_memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max BUSY cycles without mem_ack before abort; 0 disables the watchdog.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held until m0_done.
- m0_we  in  1  master 0 write enable (1 = store).
- m0_size  in  2  access size: 00 byte, 01 half, 11 word.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 store data.
- m0_gnt  out  1  master 0 owns the memory port.
- m0_done  out  1  one-cycle completion pulse.
- m0_err  out  1  valid with m0_done; 1 = timeout abort.
- m0_rdata  out  DATA_W  read data, valid with m0_done.
- m1_*  same set as m0_*, for master 1.
- mem_req  out  1  command valid to data_memory.
- mem_we  out  1  latched write enable.
- mem_size  out  2  latched size.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- cpu_stall  out  1  m0_req & ~m0_done; freezes the processor PC.
- owner  out  1  last/current granted master.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State IDLE.
  - All outputs 0, including the mem_* bus, gnt, done, err and rdata.
  - owner = 1, so master 0 wins the first tie.
  - Counter = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any req: pick a winner; both requesting gives the grant to ~owner.
  - Latch the winner's we/size/addr/wdata into the command register.
  - Set owner = winner, assert that master's gnt, and go to BUSY next edge.
  - mem_req is 1 from the first BUSY cycle.
- BUSY:
  - mem_req = 1 with the latched command, stable until exit; the counter increments each cycle.
  - mem_ack = 1: register mem_rdata to the owner's rdata (0 for writes), err = 0, go to DONE.
  - Counter reaches TIMEOUT with no ack (TIMEOUT != 0): rdata = 0, err = 1, go to DONE.
  - Ack and timeout in the same cycle: ack wins, err = 0.
- DONE:
  - Owner's done = 1 for exactly one cycle; gnt deasserts and mem_req = 0.
  - Counter clears; return to IDLE.
- Latency:
  - req seen in IDLE at edge N gives mem_req at N+1.
  - mem_ack at edge N+k gives done at N+k+1.
  - Minimum req-to-done is 3 cycles, with a 1-cycle IDLE turnaround between transactions.
- Arbitration fairness: a master that keeps req high after its done is re-granted only if the other master is idle.
- Requester rules:
  - Inputs are sampled only in IDLE; changes during BUSY are ignored.
  - Dropping req mid-transaction does not cancel it; done still pulses.
  - A req still high in the IDLE after done is a new request.
- mem_ack in IDLE or DONE is ignored.
- rdata holds its value until the next done for that master.
- Reset mid-transaction: mem_req drops immediately and no done pulse is issued.

Decomposition:
- dmem_arb_pkg holds:
  - state enum (IDLE/BUSY/DONE);
  - master IDs M0 = 0, M1 = 1;
  - size codes SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b11.
- Sub-module rr_pick2: combinational 2-way round-robin pick from (req0, req1, owner), outputting the winner and any-valid flag. All state lives in dmem_arbiter.

Test Plan:
- Single read: m0 read of 0x1000_0004; mem_ack 2 cycles after mem_req with rdata 0xDEAD_BEEF.
  - m0_done one cycle after ack with m0_rdata 0xDEAD_BEEF, m0_err 0.
  - cpu_stall high from req until done.
- Simultaneous requests after reset: m0 and m1 req together, both held.
  - Order m0, m1, m0, m1; owner toggles; no two consecutive grants to one master while the other waits.
- Write latch: m1 write addr 0x2000, data 0x0000_00AA, size 00; m1 changes addr/wdata mid-BUSY.
  - mem_addr/mem_wdata/mem_size stay 0x2000/0xAA/00 until ack.
- Timeout: TIMEOUT = 4 and mem_ack never asserted.
  - m0_done and m0_err = 1 after exactly 4 BUSY cycles, m0_rdata = 0.
  - Returns to IDLE and serves the next request normally.
- Edge cases:
  - mem_ack on the TIMEOUT cycle: err = 0.
  - Spurious mem_ack in IDLE: ignored.
  - reset asserted mid-BUSY: all outputs 0 immediately, no done; master 0 wins the first post-reset tie.
